tt_selector_conditioner: RTL and testbench

//  Input stage between raw io_in[3:0] selector switches {P,R,N,D} and the gear state machine (tt_Maquina_Top).
//  - Synchronises each switch to clk and debounces it independently.
//  - Validates the debounced vector as one-hot.
//  - Presents a clean, registered selection, a one-cycle change strobe and an error flag.

---
 rtl/tt_maquina_pkg.sv | 22 ++
 rtl/tt_debounce_bit.sv | 46 ++++
 rtl/tt_selector_conditioner.sv | 80 ++++++++
 tb/tb_tt_selector_conditioner.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/tt_maquina_pkg.sv
// Selector encodings shared by the input conditioner and the gear state machine.
// One-hot {P,R,N,D} codes, their bit positions, and a small popcount helper.
package tt_maquina_pkg;

    localparam logic [3:0] SEL_P = 4'b1000;
    localparam logic [3:0] SEL_R = 4'b0100;
    localparam logic [3:0] SEL_N = 4'b0010;
    localparam logic [3:0] SEL_D = 4'b0001;

    localparam int IDX_P = 3;
    localparam int IDX_R = 2;
    localparam int IDX_N = 1;
    localparam int IDX_D = 0;

    // Park is the only safe selection to present out of reset.
    localparam logic [3:0] SEL_RESET = SEL_P;

    function automatic logic [2:0] pop4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/tt_debounce_bit.sv
// One selector switch: SYNC_LEN-flop synchroniser followed by a saturating-free
// stability counter; the level is accepted after DB_LIMIT consecutive differing cycles.
module tt_debounce_bit #(
    parameter int SYNC_LEN = 2,
    parameter int DB_LIMIT = 50000,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    output logic db
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_LIMIT - 1);

    logic [SYNC_LEN-1:0] sync_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                s;

    assign s = sync_q[SYNC_LEN-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_LEN-2:0], sw};
        end
    end

    // A bounce back to the accepted level clears the count, so the counter
    // only reaches CNT_LAST after an unbroken run and never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            db    <= 1'b0;
        end else if (s == db) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            db    <= s;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/tt_selector_conditioner.sv
// Conditions the {P,R,N,D} selector switches into a registered one-hot selection,
// a change strobe and an error flag. Define SEL_STICKY_ERR_EN for a latched error.
module tt_selector_conditioner
    import tt_maquina_pkg::*;
#(
    parameter int DB_LIMIT = 50000,
    parameter int CNT_W    = 16,
    parameter int SYNC_LEN = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_i,
    input  logic       err_clr_i,
    output logic [3:0] sel_o,
    output logic       sel_chg_o,
    output logic       sel_err_o,
    output logic [3:0] db_o
);

    logic [2:0] db_pop;
    logic       db_onehot;
    logic       db_multi;

    for (genvar k = 0; k < 4; k++) begin : g_db
        tt_debounce_bit #(
            .SYNC_LEN (SYNC_LEN),
            .DB_LIMIT (DB_LIMIT),
            .CNT_W    (CNT_W)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .sw    (sw_i[k]),
            .db    (db_o[k])
        );
    end

    assign db_pop    = pop4(db_o);
    assign db_onehot = (db_pop == 3'd1);
    assign db_multi  = (db_pop >= 3'd2);

    // Only a clean one-hot vector may replace the selection; gaps and
    // multi-hot vectors leave the previous gear in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_o     <= SEL_RESET;
            sel_chg_o <= 1'b0;
        end else begin
            sel_chg_o <= 1'b0;
            if (db_onehot && (db_o != sel_o)) begin
                sel_o     <= db_o;
                sel_chg_o <= 1'b1;
            end
        end
    end

`ifdef SEL_STICKY_ERR_EN
    // Set has priority so a clear cannot hide an error that is still present.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_o <= 1'b0;
        end else if (db_multi) begin
            sel_err_o <= 1'b1;
        end else if (err_clr_i) begin
            sel_err_o <= 1'b0;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_o <= 1'b0;
        end else begin
            sel_err_o <= db_multi;
        end
    end
`endif

endmodule

// File: tb/tb_tt_selector_conditioner.sv
// Directed self-checking bench for tt_selector_conditioner with DB_LIMIT=4, SYNC_LEN=2.
// Define SEL_STICKY_ERR_EN to exercise the latched-error build.
module tb_tt_selector_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw_i;
    logic       err_clr_i;
    logic [3:0] sel_o;
    logic       sel_chg_o;
    logic       sel_err_o;
    logic [3:0] db_o;

    int compare_cnt = 0;
    int fail_cnt    = 0;
    int pulse_cnt   = 0;

    tt_selector_conditioner #(
        .DB_LIMIT (4),
        .CNT_W    (16),
        .SYNC_LEN (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_i      (sw_i),
        .err_clr_i (err_clr_i),
        .sel_o     (sel_o),
        .sel_chg_o (sel_chg_o),
        .sel_err_o (sel_err_o),
        .db_o      (db_o)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 ns after each and tallying strobes seen.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (sel_chg_o) pulse_cnt++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compare_cnt++;
        assert (observed === expected)
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        sw_i      = 4'b0101;
        err_clr_i = 1'b0;

        // 1: reset values
        applyStimulus(3);
        checkOutput("rst_sel", 32'(sel_o), 32'h8);
        checkOutput("rst_chg", 32'(sel_chg_o), 32'h0);
        checkOutput("rst_err", 32'(sel_err_o), 32'h0);
        checkOutput("rst_db", 32'(db_o), 32'h0);
        rst_n = 1'b1;
        applyStimulus(1);
        checkOutput("rel_sel", 32'(sel_o), 32'h8);
        checkOutput("rel_db", 32'(db_o), 32'h0);
        sw_i = 4'b1000;
        pulse_cnt = 0;
        applyStimulus(12);
        checkOutput("park_db", 32'(db_o), 32'h8);
        checkOutput("park_sel", 32'(sel_o), 32'h8);
        checkOutput("park_pulses", 32'(pulse_cnt), 32'h0);

        // 2: clean P->D, strobe exactly 7 cycles after the edge
        sw_i = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1);
            checkOutput($sformatf("lat_chg_%0d", k), 32'(sel_chg_o), (k == 7) ? 32'h1 : 32'h0);
            checkOutput($sformatf("lat_sel_%0d", k), 32'(sel_o), (k >= 7) ? 32'h1 : 32'h8);
        end
        checkOutput("lat_db", 32'(db_o), 32'h1);

        // back to Park for the bounce test
        sw_i = 4'b1000;
        pulse_cnt = 0;
        applyStimulus(10);
        checkOutput("repark_sel", 32'(sel_o), 32'h8);
        checkOutput("repark_pulses", 32'(pulse_cnt), 32'h1);

        // 3: bit 0 bouncing every 2 cycles never gets accepted
        pulse_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            sw_i = {3'b100, ((i / 2) % 2 == 0)};
            applyStimulus(1);
            checkOutput($sformatf("bounce_db_%0d", i), 32'(db_o), 32'h8);
        end
        sw_i = 4'b1000;
        applyStimulus(10);
        checkOutput("bounce_sel", 32'(sel_o), 32'h8);
        checkOutput("bounce_db", 32'(db_o), 32'h8);
        checkOutput("bounce_pulses", 32'(pulse_cnt), 32'h0);

        // 4: multi-hot error, then valid N, then a 0000 gap
        sw_i = 4'b0011;
        pulse_cnt = 0;
        applyStimulus(10);
        checkOutput("multi_err", 32'(sel_err_o), 32'h1);
        checkOutput("multi_sel", 32'(sel_o), 32'h8);
        checkOutput("multi_pulses", 32'(pulse_cnt), 32'h0);
        sw_i = 4'b0010;
        applyStimulus(10);
        checkOutput("n_sel", 32'(sel_o), 32'h2);
        checkOutput("n_pulses", 32'(pulse_cnt), 32'h1);
`ifdef SEL_STICKY_ERR_EN
        checkOutput("n_err_sticky", 32'(sel_err_o), 32'h1);
        err_clr_i = 1'b1;
        applyStimulus(1);
        err_clr_i = 1'b0;
        checkOutput("clr_err", 32'(sel_err_o), 32'h0);
`else
        checkOutput("n_err", 32'(sel_err_o), 32'h0);
`endif
        sw_i = 4'b0000;
        pulse_cnt = 0;
        applyStimulus(10);
        checkOutput("gap_db", 32'(db_o), 32'h0);
        checkOutput("gap_sel", 32'(sel_o), 32'h2);
        checkOutput("gap_err", 32'(sel_err_o), 32'h0);
        checkOutput("gap_pulses", 32'(pulse_cnt), 32'h0);

        // 5: reset in the middle of a pending D debounce
        sw_i = 4'b0001;
        applyStimulus(2);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_sel", 32'(sel_o), 32'h8);
        checkOutput("mid_rst_db", 32'(db_o), 32'h0);
        checkOutput("mid_rst_chg", 32'(sel_chg_o), 32'h0);
        applyStimulus(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1);
            checkOutput($sformatf("post_rst_chg_%0d", k), 32'(sel_chg_o), (k == 7) ? 32'h1 : 32'h0);
            checkOutput($sformatf("post_rst_sel_%0d", k), 32'(sel_o), (k == 7) ? 32'h1 : 32'h8);
        end

        // 6: error flag behaviour with err_clr_i while multi-hot is present
        sw_i = 4'b0011;
        applyStimulus(10);
        checkOutput("e6_err_set", 32'(sel_err_o), 32'h1);
        err_clr_i = 1'b1;
        applyStimulus(1);
        err_clr_i = 1'b0;
        checkOutput("e6_clr_blocked", 32'(sel_err_o), 32'h1);
        sw_i = 4'b0010;
        applyStimulus(10);
        checkOutput("e6_sel", 32'(sel_o), 32'h2);
`ifdef SEL_STICKY_ERR_EN
        checkOutput("e6_err_held", 32'(sel_err_o), 32'h1);
        err_clr_i = 1'b1;
        applyStimulus(1);
        err_clr_i = 1'b0;
        checkOutput("e6_err_cleared", 32'(sel_err_o), 32'h0);
`else
        checkOutput("e6_err_dropped", 32'(sel_err_o), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, fail_cnt);
        $finish;
    end

endmodule
